// File: rtl/reset_sequencer.sv
// Synchronises NUM_CHANNELS async active-low reset requests, holds every output low for HOLD_CYCLES,
// then releases the outputs one channel at a time, STAGGER_CYCLES apart, in fixed index order.
module reset_sequencer #(
   parameter int NUM_CHANNELS   = 4,
   parameter int SYNC_STAGES    = 3,
   parameter int HOLD_CYCLES    = 8,
   parameter int STAGGER_CYCLES = 2
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] req_resetn_in,
   input  logic                    clear_cause,
   output logic [NUM_CHANNELS-1:0] resetn_out,
   output logic                    all_released,
   output logic [NUM_CHANNELS-1:0] reset_cause
);

   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
   localparam int IDX_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CHANNELS - 1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_CHANNELS-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NUM_CHANNELS-1:0]                  chain_out;
   logic                                     all_sync;
   logic                                     leave;

   logic [HOLD_W-1:0]       hold_cnt, hold_d;
   logic [STAG_W-1:0]       stag_cnt, stag_d;
   logic [IDX_W-1:0]        idx, idx_d;
   logic [NUM_CHANNELS-1:0] resetn_d;
   logic [NUM_CHANNELS-1:0] cause_d;
   logic                    all_rel_d;

   // Reset clears the chains, so every request reads as asserted until it has crossed.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], req_resetn_in[i]};
         end
      end
   end

   always_comb begin
      chain_out = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         chain_out[i] = sync_q[i][SYNC_STAGES-1];
      end
   end

   assign all_sync = &chain_out;
   assign leave    = (state_q != ST_HOLD) && !all_sync;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_HOLD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_HOLD: begin
            if (all_sync && (hold_cnt == HOLD_LAST)) begin
               state_d = (NUM_CHANNELS == 1) ? ST_RUN : ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            if (!all_sync) begin
               state_d = ST_HOLD;
            end else if ((stag_cnt == STAG_LAST) && (idx == IDX_LAST)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!all_sync) begin
               state_d = ST_HOLD;
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      hold_d   = hold_cnt;
      stag_d   = stag_cnt;
      idx_d    = idx;
      resetn_d = resetn_out;
      // A new set lands on top of a same-edge clear.
      cause_d  = (clear_cause ? '0 : reset_cause) | (leave ? ~chain_out : '0);
      case (state_q)
         ST_HOLD: begin
            resetn_d = '0;
            if (!all_sync) begin
               hold_d = '0;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_d = hold_cnt + 1'b1;
            end else begin
               resetn_d[0] = 1'b1;
               idx_d       = IDX_W'(1);
               stag_d      = '0;
            end
         end
         ST_RELEASE: begin
            if (leave) begin
               resetn_d = '0;
               hold_d   = '0;
               idx_d    = '0;
            end else if (stag_cnt == STAG_LAST) begin
               for (int k = 0; k < NUM_CHANNELS; k++) begin
                  if (idx == IDX_W'(k)) begin
                     resetn_d[k] = 1'b1;
                  end
               end
               stag_d = '0;
               if (idx != IDX_LAST) begin
                  idx_d = idx + 1'b1;
               end
            end else begin
               stag_d = stag_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (leave) begin
               resetn_d = '0;
               hold_d   = '0;
               idx_d    = '0;
            end else begin
               resetn_d = '1;
            end
         end
         default: begin
            resetn_d = '0;
            hold_d   = '0;
            idx_d    = '0;
         end
      endcase
      all_rel_d = &resetn_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         hold_cnt     <= '0;
         stag_cnt     <= '0;
         idx          <= '0;
         resetn_out   <= '0;
         all_released <= 1'b0;
         reset_cause  <= '0;
      end else begin
         hold_cnt     <= hold_d;
         stag_cnt     <= stag_d;
         idx          <= idx_d;
         resetn_out   <= resetn_d;
         all_released <= all_rel_d;
         reset_cause  <= cause_d;
      end
   end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised successor to the single-output reset synchroniser. It synchronises NUM_CHANNELS asynchronous active-low reset requests into the clock domain and holds all downstream resets asserted for a minimum time. It then releases the downstream resets one channel at a time in fixed order, with a programmable stagger. It sits at the clock-domain boundary and feeds per-kernel and per-interface resets, so downstream blocks leave reset in a known order.

Parameters:
NUM_CHANNELS, 4, number of reset request inputs and sequenced reset outputs (1..16)
SYNC_STAGES, 3, flops per request synchroniser chain (>=2)
HOLD_CYCLES, 8, minimum cycles all synchronised requests must be deasserted before release starts (>=1)
STAGGER_CYCLES, 2, cycles between releasing channel k and channel k+1 (>=1)

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high master reset
req_resetn_in  input  NUM_CHANNELS  asynchronous active-low reset requests, one per channel
clear_cause  input  1  single-cycle pulse; clears reset_cause
resetn_out  output  NUM_CHANNELS  sequenced active-low resets, registered
all_released  output  1  high when every resetn_out bit is high
reset_cause  output  NUM_CHANNELS  sticky record of the channels whose request forced the last re-sequence

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (reset=1 at an edge) takes effect at that edge, from any state: sync chains=0 (requests treated as asserted), resetn_out=0, all_released=0, reset_cause=0, hold/stagger counters=0, channel index=0, state=HOLD.
- Synchroniser: per channel, SYNC_STAGES-deep shift chain of req_resetn_in[i]. all_sync = AND of the chain outputs.
- Minimum request pulse is one clock period. Narrower pulses may be missed.
- States:
  - HOLD: resetn_out=0. If all_sync=0, hold_cnt<=0. If all_sync=1 and hold_cnt<HOLD_CYCLES-1, hold_cnt++. If all_sync=1 and hold_cnt==HOLD_CYCLES-1: resetn_out[0]<=1, idx<=1, stag_cnt<=0, go to RELEASE (or RUN if NUM_CHANNELS==1).
  - RELEASE: stag_cnt++ each edge. When stag_cnt==STAGGER_CYCLES-1: resetn_out[idx]<=1, stag_cnt<=0, idx++. When the last channel is released, go to RUN.
  - RUN: all resetn_out=1.
- all_released is registered and rises at the same edge as resetn_out[NUM_CHANNELS-1].
- Any all_sync=0 while in RELEASE or RUN, at that edge: all resetn_out<=0, all_released<=0, hold_cnt<=0, idx<=0, go to HOLD. Already-released channels drop together, in the same cycle.
- Latency (first edge with reset=0 and requests high = edge 1): all_sync=1 after edge SYNC_STAGES. resetn_out[k] rises after edge SYNC_STAGES+HOLD_CYCLES+k*STAGGER_CYCLES.
- Request assertion sampled at edge a: resetn_out falls after edge a+SYNC_STAGES.
- reset_cause:
  - At each edge where the state leaves RELEASE/RUN for HOLD, bits set for every channel whose chain output is 0. OR-accumulated, never self-clearing.
  - Requests arriving while already in HOLD do not set cause bits.
  - clear_cause=1 zeroes reset_cause. If clear and set occur at the same edge, set wins for the newly set bits.
- Boundary cases:
  - Request reasserted during HOLD restarts hold_cnt from 0. Partial hold time is never credited.
  - reset dominates clear_cause and all requests.
  - Counters are sized clog2 of their limit (minimum 1 bit) and never wrap.

Test Plan:
- Defaults, reset high 3 cycles then low, all requests high -> resetn_out bits rise after edges 11,13,15,17; all_released rises after edge 17; reset_cause=0.
- In RUN, drive req_resetn_in[2]=0 for 1 cycle sampled at edge a -> resetn_out=4'b0000 after edge a+3, reset_cause=4'b0100, full re-sequence starts; channel 0 high 3+8 edges after request returns high.
- Request drops on channel 1 at hold_cnt=5 in HOLD -> hold_cnt restarts; no release until 8 consecutive all_sync=1 cycles; reset_cause unchanged.
- Requests 0 and 3 drop in the same cycle during RELEASE (after channel 1 released) -> all outputs low together; reset_cause=4'b1001; clear_cause in the set cycle -> 4'b1001 retained; a later clear_cause -> 4'b0000.
- reset asserted mid-RELEASE -> next edge all outputs 0, reset_cause 0, sequence restarts from the timeline of scenario 1.
- NUM_CHANNELS=1, SYNC_STAGES=2, HOLD_CYCLES=1, STAGGER_CYCLES=1 -> resetn_out and all_released rise after edge 3.
